fetch_sequencer: RTL and testbench

Control block that sequences instruction fetch for each core. It drives `pc_select` and the clock-enable of the program counter, and handshakes with the L1 instruction side. It takes control-transfer resolutions from execute, applies each as a single PC redirect, then inserts a configurable number of flush bubbles. It stalls the PC whenever the instruction fetch is outstanding or the data side of the L1 hierarchy is busy.

---
 rtl/fetch_pkg.sv | 25 ++
 rtl/fetch_sequencer_if.sv | 28 ++
 rtl/fetch_sequencer_sat_counter.sv | 20 ++
 rtl/fetch_sequencer.sv | 109 ++++++++++
 tb/tb_fetch_sequencer.sv | 139 +++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared fetch-sequencer types: FSM state encoding and PC source selects.
// The PC block imports the same PCSEL_* constants.
package fetch_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FETCH    = 3'd1,
        ST_WAIT_MEM = 3'd2,
        ST_REDIRECT = 3'd3,
        ST_FLUSH    = 3'd4
    } fetch_state_t;

    localparam logic [1:0] PCSEL_INC  = 2'b00;
    localparam logic [1:0] PCSEL_BR   = 2'b01;
    localparam logic [1:0] PCSEL_JAL  = 2'b10;
    localparam logic [1:0] PCSEL_JALR = 2'b11;

    // Target priority when several resolve flags are set: jalr > jal > branch.
    function automatic logic [1:0] redir_sel(input logic jal, input logic jalr);
        if (jalr)     return PCSEL_JALR;
        else if (jal) return PCSEL_JAL;
        else          return PCSEL_BR;
    endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Fetch-control bundle between the sequencer (master) and the L1 I-side,
// execute stage and PC block (slave).
interface fetch_sequencer_if;

    logic       imem_req;
    logic       imem_ready;
    logic       dmem_busy;
    logic       ex_valid;
    logic       ex_branch;
    logic       ex_taken;
    logic       ex_jal;
    logic       ex_jalr;
    logic [1:0] pc_select;
    logic       pc_hold;
    logic       flush;
    logic       instr_valid;

    modport master (
        output imem_req, pc_select, pc_hold, flush, instr_valid,
        input  imem_ready, dmem_busy, ex_valid, ex_branch, ex_taken, ex_jal, ex_jalr
    );

    modport slave (
        input  imem_req, pc_select, pc_hold, flush, instr_valid,
        output imem_ready, dmem_busy, ex_valid, ex_branch, ex_taken, ex_jal, ex_jalr
    );

endinterface

// File: rtl/fetch_sequencer_sat_counter.sv
// Width-parameterised saturating event counter with enable.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                   cnt_q <= '0;
        else if (en_i && cnt_q != '1) cnt_q <= cnt_q + W'(1);
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Per-core fetch sequencer: PC advance/hold, redirect + flush bubbles, memory stalls.
// Optional perf counters (stall_count, flush_count) under FETCH_SEQ_PERF_EN.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int CNT_W        = 16,
    parameter int FLUSH_CYCLES = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    fetch_sequencer_if.master   bus,
    output logic [2:0]          fsm_state
`ifdef FETCH_SEQ_PERF_EN
    ,
    output logic [CNT_W-1:0]    stall_count,
    output logic [CNT_W-1:0]    flush_count
`endif
);

    localparam logic [2:0] BUB_LAST = 3'(FLUSH_CYCLES - 1);

    fetch_state_t state_q, state_d;
    logic         imem_req_q, flush_q, pend_v_q;
    logic [1:0]   pend_sel_q;
    logic [2:0]   bub_q;
    logic         redir, advance;

    assign redir   = bus.ex_valid & ((bus.ex_branch & bus.ex_taken) | bus.ex_jal | bus.ex_jalr);
    assign advance = bus.imem_ready & ~bus.dmem_busy;

    // WAIT_MEM completes its fetch in the cycle memory answers, exactly as FETCH would.
    always_comb begin
        state_d         = state_q;
        bus.pc_hold     = 1'b1;
        bus.pc_select   = PCSEL_INC;
        bus.instr_valid = 1'b0;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_FETCH;
            ST_FETCH, ST_WAIT_MEM: begin
                if (advance) begin
                    bus.instr_valid = 1'b1;
                    if (pend_v_q || redir) begin
                        state_d = ST_REDIRECT;
                    end else begin
                        bus.pc_hold = 1'b0;
                        state_d     = ST_FETCH;
                    end
                end else begin
                    state_d = ST_WAIT_MEM;
                end
            end
            ST_REDIRECT: begin
                bus.pc_select = pend_sel_q;
                if (!bus.dmem_busy) begin
                    bus.pc_hold = 1'b0;
                    state_d     = ST_FLUSH;
                end
            end
            ST_FLUSH: if (!bus.dmem_busy && bub_q == BUB_LAST) state_d = ST_FETCH;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            imem_req_q <= 1'b0;
            flush_q    <= 1'b0;
            pend_v_q   <= 1'b0;
            pend_sel_q <= PCSEL_INC;
            bub_q      <= '0;
        end else begin
            state_q    <= state_d;
            imem_req_q <= (state_d == ST_FETCH) || (state_d == ST_WAIT_MEM);
            flush_q    <= (state_d == ST_REDIRECT) || (state_d == ST_FLUSH);
            // Only one redirect can be in flight; later ones are dropped until consumed.
            if (state_q == ST_REDIRECT && state_d == ST_FLUSH) begin
                pend_v_q <= 1'b0;
            end else if (redir && !pend_v_q) begin
                pend_v_q   <= 1'b1;
                pend_sel_q <= redir_sel(bus.ex_jal, bus.ex_jalr);
            end
            if (state_q != ST_FLUSH)    bub_q <= '0;
            else if (!bus.dmem_busy)    bub_q <= bub_q + 3'd1;
        end
    end

    assign bus.imem_req = imem_req_q;
    assign bus.flush    = flush_q;
    assign fsm_state    = state_q;

`ifdef FETCH_SEQ_PERF_EN
    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .en_i  (state_q == ST_WAIT_MEM),
        .cnt_o (stall_count)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .en_i  (state_q != ST_REDIRECT && state_d == ST_REDIRECT),
        .cnt_o (flush_count)
    );
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer with FLUSH_CYCLES=2; counters checked when
// FETCH_SEQ_PERF_EN is defined.
module tb_fetch_sequencer;
    import fetch_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [2:0] fsm_state;
`ifdef FETCH_SEQ_PERF_EN
    logic [15:0] stall_count, flush_count;
`endif

    fetch_sequencer_if bus ();

    fetch_sequencer #(.CNT_W(16), .FLUSH_CYCLES(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .bus       (bus),
        .fsm_state (fsm_state)
`ifdef FETCH_SEQ_PERF_EN
        ,
        .stall_count (stall_count),
        .flush_count (flush_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic [8:0] v;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    // in = {start, imem_ready, dmem_busy, ex_valid, ex_branch, ex_taken, ex_jal, ex_jalr}
    // expected vector = {fsm_state, pc_hold, pc_select, flush, instr_valid, imem_req}
    task automatic cyc(input string tag, input logic [7:0] in, input fetch_state_t est,
                       input logic ehold, input logic [1:0] esel,
                       input logic efl, input logic eiv, input logic ereq);
        exp_t e;
        {start, bus.imem_ready, bus.dmem_busy, bus.ex_valid,
         bus.ex_branch, bus.ex_taken, bus.ex_jal, bus.ex_jalr} = in;
        e.tag = tag;
        e.v   = {est, ehold, esel, efl, eiv, ereq};
        sb.push_back(e);
        #1;
        e = sb.pop_front();
        chk(e.tag, 32'({fsm_state, bus.pc_hold, bus.pc_select, bus.flush,
                        bus.instr_valid, bus.imem_req}), 32'(e.v));
        @(negedge clk);
    endtask

    task automatic chk_cnt(input string tag, input int stalls, input int flushes);
`ifdef FETCH_SEQ_PERF_EN
        chk({tag, "_stall"}, 32'(stall_count), 32'(stalls));
        chk({tag, "_flush"}, 32'(flush_count), 32'(flushes));
`else
        if (stalls < 0 || flushes < 0) $display("bad counter request %s", tag);
`endif
    endtask

    initial begin
        {start, bus.imem_ready, bus.dmem_busy, bus.ex_valid,
         bus.ex_branch, bus.ex_taken, bus.ex_jal, bus.ex_jalr} = '0;
        @(negedge clk);
        cyc("reset", 8'b0000_0000, ST_IDLE, 1, 2'b00, 0, 0, 0);
        chk_cnt("reset", 0, 0);
        reset = 1'b0;

        // zero-wait streaming
        cyc("idle_start", 8'b1100_0000, ST_IDLE,  1, 2'b00, 0, 0, 0);
        for (int i = 0; i < 3; i++)
            cyc("stream", 8'b0100_0000, ST_FETCH, 0, 2'b00, 0, 1, 1);

        // imem_ready low for 3 cycles
        cyc("miss0", 8'b0000_0000, ST_FETCH,    1, 2'b00, 0, 0, 1);
        cyc("miss1", 8'b0000_0000, ST_WAIT_MEM, 1, 2'b00, 0, 0, 1);
        cyc("miss2", 8'b0000_0000, ST_WAIT_MEM, 1, 2'b00, 0, 0, 1);
        cyc("miss_done", 8'b0100_0000, ST_WAIT_MEM, 0, 2'b00, 0, 1, 1);
        cyc("after_miss", 8'b0100_0000, ST_FETCH, 0, 2'b00, 0, 1, 1);
        chk_cnt("miss", 3, 0);

        // jal + jalr together: jalr wins
        cyc("jj_resolve", 8'b0101_0011, ST_FETCH,    1, 2'b00, 0, 1, 1);
        cyc("jj_redir",   8'b0100_0000, ST_REDIRECT, 0, 2'b11, 1, 0, 0);
        cyc("jj_flush0",  8'b0100_0000, ST_FLUSH,    1, 2'b00, 1, 0, 0);
        cyc("jj_flush1",  8'b0100_0000, ST_FLUSH,    1, 2'b00, 1, 0, 0);
        cyc("jj_refetch", 8'b0100_0000, ST_FETCH,    0, 2'b00, 0, 1, 1);
        chk_cnt("jj", 3, 1);

        // branch not taken
        cyc("bnt",      8'b0101_1000, ST_FETCH, 0, 2'b00, 0, 1, 1);
        cyc("bnt_next", 8'b0100_0000, ST_FETCH, 0, 2'b00, 0, 1, 1);

        // taken branch under 4 cycles of dmem_busy, then busy during REDIRECT and FLUSH
        cyc("bt_busy0", 8'b0111_1100, ST_FETCH, 1, 2'b00, 0, 0, 1);
        for (int i = 1; i < 4; i++)
            cyc("bt_busy", 8'b0110_0000, ST_WAIT_MEM, 1, 2'b00, 0, 0, 1);
        cyc("bt_release",  8'b0100_0000, ST_WAIT_MEM, 1, 2'b00, 0, 1, 1);
        cyc("bt_redir_bz", 8'b0110_0000, ST_REDIRECT, 1, 2'b01, 1, 0, 0);
        cyc("bt_redir",    8'b0100_0000, ST_REDIRECT, 0, 2'b01, 1, 0, 0);
        cyc("bt_flush_bz", 8'b0110_0000, ST_FLUSH,    1, 2'b00, 1, 0, 0);
        cyc("bt_flush0",   8'b0100_0000, ST_FLUSH,    1, 2'b00, 1, 0, 0);
        cyc("bt_flush1",   8'b0100_0000, ST_FLUSH,    1, 2'b00, 1, 0, 0);
        cyc("bt_refetch",  8'b0100_0000, ST_FETCH,    0, 2'b00, 0, 1, 1);
        chk_cnt("bt", 7, 2);

        // reset in the middle of FLUSH
        cyc("jal_resolve", 8'b0101_0010, ST_FETCH,    1, 2'b00, 0, 1, 1);
        cyc("jal_redir",   8'b0100_0000, ST_REDIRECT, 0, 2'b10, 1, 0, 0);
        cyc("jal_flush0",  8'b0100_0000, ST_FLUSH,    1, 2'b00, 1, 0, 0);
        reset = 1'b1;
        cyc("rst_mid",     8'b0100_0000, ST_IDLE,     1, 2'b00, 0, 0, 0);
        chk_cnt("rst_mid", 0, 0);
        reset = 1'b0;
        cyc("re_start",  8'b1100_0000, ST_IDLE,  1, 2'b00, 0, 0, 0);
        cyc("re_fetch0", 8'b0100_0000, ST_FETCH, 0, 2'b00, 0, 1, 1);
        cyc("re_fetch1", 8'b0100_0000, ST_FETCH, 0, 2'b00, 0, 1, 1);
        chk_cnt("re_fetch", 0, 0);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
